// File: rtl/input_layer_loader.sv
`default_nettype none
// ============================================================================
//  Module      : input_layer_loader
//  Description : Sequencer feeding the input convolution layer. Per run it
//                loads all kernel weights, then one input image, from a
//                valid/ready word stream, then counts the layer's
//                output_valid pulses until the full feature map is out.
//  Revision    : 1.0  initial release
// ============================================================================
module input_layer_loader #(
    parameter int DATA_SIZE   = 64,
    parameter int NUM_INPUTS  = 1,
    parameter int NUM_OUTPUTS = 16,
    parameter int INPUT_DIM   = 28,
    parameter int KERNEL_DIM  = 3,
    parameter int IDX_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_SIZE-1:0] write_data,
    output logic [IDX_W-1:0]     in_index3,
    output logic [IDX_W-1:0]     in_index2,
    output logic [IDX_W-1:0]     in_index1,
    output logic [IDX_W-1:0]     in_index0,
    output logic                 want_write_weights,
    output logic                 want_write_act,
    input  logic                 output_valid,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     out_count
);

    // Last legal value of each index and the size of the output feature map
    localparam logic [IDX_W-1:0] c_k_last   = IDX_W'(KERNEL_DIM - 1);
    localparam logic [IDX_W-1:0] c_d_last   = IDX_W'(INPUT_DIM - 1);
    localparam logic [IDX_W-1:0] c_ich_last = IDX_W'(NUM_INPUTS - 1);
    localparam logic [IDX_W-1:0] c_och_last = IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [IDX_W-1:0] c_no       =
        IDX_W'(NUM_OUTPUTS * (INPUT_DIM - KERNEL_DIM + 1) * (INPUT_DIM - KERNEL_DIM + 1));

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_A = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       cnt3_q, cnt3_d, cnt2_q, cnt2_d, cnt1_q, cnt1_d, cnt0_q, cnt0_d;
    logic [IDX_W-1:0]       idx3_q, idx3_d, idx2_q, idx2_d, idx1_q, idx1_d, idx0_q, idx0_d;
    logic [DATA_SIZE-1:0]   wdata_q, wdata_d;
    logic                   ww_q, ww_d, wa_q, wa_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d, done_q, done_d;
    logic [IDX_W-1:0]       out_count_q, out_count_d;

    logic                   w_xfer;
    logic                   w_last;
    logic [IDX_W-1:0]       w_lim_rc;
    logic [IDX_W-1:0]       w_lim_och;
    logic [IDX_W-1:0]       w_count_inc;

    // Next-state, load-index sequencing and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt3_d      = cnt3_q;
        cnt2_d      = cnt2_q;
        cnt1_d      = cnt1_q;
        cnt0_d      = cnt0_q;
        idx3_d      = idx3_q;
        idx2_d      = idx2_q;
        idx1_d      = idx1_q;
        idx0_d      = idx0_q;
        wdata_d     = wdata_q;
        ww_d        = 1'b0;
        wa_d        = 1'b0;
        out_count_d = out_count_q;

        // in_ready_q is only ever high in the two load states
        w_xfer      = in_valid && in_ready_q;
        w_lim_rc    = (state_q == S_LOAD_W) ? c_k_last : c_d_last;
        w_lim_och   = (state_q == S_LOAD_W) ? c_och_last : '0;
        w_last      = (cnt0_q == w_lim_rc) && (cnt1_q == w_lim_rc) &&
                      (cnt2_q == c_ich_last) && (cnt3_q == w_lim_och);
        w_count_inc = out_count_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD_W;
                    out_count_d = '0;
                    cnt3_d      = '0;
                    cnt2_d      = '0;
                    cnt1_d      = '0;
                    cnt0_d      = '0;
                end
            end
            S_LOAD_W, S_LOAD_A: begin
                if (w_xfer) begin
                    wdata_d = in_data;
                    idx3_d  = cnt3_q;
                    idx2_d  = cnt2_q;
                    idx1_d  = cnt1_q;
                    idx0_d  = cnt0_q;
                    ww_d    = (state_q == S_LOAD_W);
                    wa_d    = (state_q == S_LOAD_A);
                    // Odometer: each digit wraps to 0, so the final element
                    // leaves all counters cleared for the next phase.
                    if (cnt0_q != w_lim_rc) begin
                        cnt0_d = cnt0_q + 1'b1;
                    end else begin
                        cnt0_d = '0;
                        if (cnt1_q != w_lim_rc) begin
                            cnt1_d = cnt1_q + 1'b1;
                        end else begin
                            cnt1_d = '0;
                            if (cnt2_q != c_ich_last) begin
                                cnt2_d = cnt2_q + 1'b1;
                            end else begin
                                cnt2_d = '0;
                                if (cnt3_q != w_lim_och) begin
                                    cnt3_d = cnt3_q + 1'b1;
                                end else begin
                                    cnt3_d = '0;
                                end
                            end
                        end
                    end
                    if (w_last) begin
                        state_d = (state_q == S_LOAD_W) ? S_LOAD_A : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (output_valid && (out_count_q != c_no)) begin
                    out_count_d = w_count_inc;
                    if (w_count_inc == c_no) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered
        in_ready_d = (state_d == S_LOAD_W) || (state_d == S_LOAD_A);
        busy_d     = in_ready_d || (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt3_q      <= '0;
            cnt2_q      <= '0;
            cnt1_q      <= '0;
            cnt0_q      <= '0;
            idx3_q      <= '0;
            idx2_q      <= '0;
            idx1_q      <= '0;
            idx0_q      <= '0;
            wdata_q     <= '0;
            ww_q        <= 1'b0;
            wa_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt3_q      <= cnt3_d;
            cnt2_q      <= cnt2_d;
            cnt1_q      <= cnt1_d;
            cnt0_q      <= cnt0_d;
            idx3_q      <= idx3_d;
            idx2_q      <= idx2_d;
            idx1_q      <= idx1_d;
            idx0_q      <= idx0_d;
            wdata_q     <= wdata_d;
            ww_q        <= ww_d;
            wa_q        <= wa_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign write_data         = wdata_q;
    assign in_index3          = idx3_q;
    assign in_index2          = idx2_q;
    assign in_index1          = idx1_q;
    assign in_index0          = idx0_q;
    assign want_write_weights = ww_q;
    assign want_write_act     = wa_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign out_count          = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_input_layer_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_input_layer_loader
//  Description : Self-checking bench for input_layer_loader. Expected writes
//                are queued as words are driven and compared as strobes
//                appear; status outputs are checked at directed points.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_layer_loader;

    localparam int DW   = 64;
    localparam int IW   = 16;
    localparam int NOUT = 16;
    localparam int NIN  = 1;
    localparam int D    = 28;
    localparam int K    = 3;
    localparam int NO   = NOUT * (D - K + 1) * (D - K + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] write_data;
    logic [IW-1:0] in_index3, in_index2, in_index1, in_index0;
    logic          want_write_weights, want_write_act;
    logic          output_valid;
    logic          busy, done;
    logic [IW-1:0] out_count;

    typedef struct {
        logic          is_w;
        logic [DW-1:0] data;
        logic [IW-1:0] i3, i2, i1, i0;
    } exp_t;

    exp_t sb[$];
    exp_t last_w;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    input_layer_loader dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .write_data         (write_data),
        .in_index3          (in_index3),
        .in_index2          (in_index2),
        .in_index1          (in_index1),
        .in_index0          (in_index0),
        .want_write_weights (want_write_weights),
        .want_write_act     (want_write_act),
        .output_valid       (output_valid),
        .busy               (busy),
        .done               (done),
        .out_count          (out_count)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_last();
        last_w.is_w = 1'b0;
        last_w.data = '0;
        last_w.i3   = '0;
        last_w.i2   = '0;
        last_w.i1   = '0;
        last_w.i0   = '0;
    endtask

    // One clock; then pop/compare any write, or check that outputs held
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (want_write_weights === 1'b1 || want_write_act === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 128'({want_write_weights, want_write_act}), 128'(2'b00));
                end else begin
                    e = sb.pop_front();
                    chk("strobe_kind", 128'({want_write_weights, want_write_act}),
                        128'(e.is_w ? 2'b10 : 2'b01));
                    chk("write_data", 128'(write_data), 128'(e.data));
                    chk("write_index", 128'({in_index3, in_index2, in_index1, in_index0}),
                        128'({e.i3, e.i2, e.i1, e.i0}));
                    last_w = e;
                end
            end else begin
                chk("strobe_low", 128'({want_write_weights, want_write_act}), 128'(2'b00));
                chk("data_hold", 128'(write_data), 128'(last_w.data));
                chk("index_hold", 128'({in_index3, in_index2, in_index1, in_index0}),
                    128'({last_w.i3, last_w.i2, last_w.i1, last_w.i0}));
            end
        end
    endtask

    // Drive one word for one cycle and queue the write it should produce
    task automatic send(input logic is_w, input int i3, input int i2, input int i1, input int i0);
        exp_t e;
        e.is_w   = is_w;
        e.data   = {$urandom, $urandom};
        e.i3     = IW'(i3);
        e.i2     = IW'(i2);
        e.i1     = IW'(i1);
        e.i0     = IW'(i0);
        in_data  = e.data;
        in_valid = 1'b1;
        chk("in_ready_at_send", 128'(in_ready), 128'(1'b1));
        sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_data      = '0;
        in_valid     = 1'b0;
        output_valid = 1'b0;
        clear_last();
        @(posedge clk); #1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rst    = 1'b0;

        // Reset / idle state
        repeat (5) tick();
        chk("rst_in_ready",  128'(in_ready),  128'(1'b0));
        chk("rst_busy",      128'(busy),      128'(1'b0));
        chk("rst_done",      128'(done),      128'(1'b0));
        chk("rst_out_count", 128'(out_count), 128'(0));

        // Run 1: weights every cycle, output_valid held high (must be ignored)
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy",     128'(busy),     128'(1'b1));
        chk("start_in_ready", 128'(in_ready), 128'(1'b1));
        output_valid = 1'b1;
        for (int o = 0; o < NOUT; o++)
            for (int c = 0; c < NIN; c++)
                for (int r = 0; r < K; r++)
                    for (int k = 0; k < K; k++)
                        send(1'b1, o, c, r, k);

        // Activations follow seamlessly, then with in_valid toggling;
        // a start pulse mid-load must be ignored
        for (int c = 0; c < NIN; c++)
            for (int r = 0; r < D; r++)
                for (int k = 0; k < D; k++) begin
                    if (r == 10 && k == 5) start = 1'b1;
                    send(1'b0, 0, c, r, k);
                    start = 1'b0;
                    if (!(c == NIN - 1 && r == D - 1 && k == D - 1)) tick();
                end
        output_valid = 1'b0;
        chk("in_ready_after_load", 128'(in_ready),   128'(1'b0));
        chk("busy_in_run",         128'(busy),       128'(1'b1));
        chk("no_count_outside_run", 128'(out_count), 128'(0));
        chk("queue_empty_load",    128'(sb.size()),  128'(0));
        tick();
        chk("in_ready_run_idle",   128'(in_ready),   128'(1'b0));

        // Output counting with gaps
        for (int i = 0; i < NO; i++) begin
            output_valid = 1'b1;
            tick();
            output_valid = 1'b0;
            chk("out_count", 128'(out_count), 128'(i + 1));
            chk("done",      128'(done),      128'(i == NO - 1));
            chk("busy",      128'(busy),      128'(i != NO - 1));
            if (i != NO - 1 && (i % 4) == 1) tick();
        end

        // start during DONE is ignored; count holds after the run
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_one_cycle", 128'(done), 128'(1'b0));
        chk("busy_after_done", 128'(busy), 128'(1'b0));
        output_valid = 1'b1;
        tick();
        tick();
        output_valid = 1'b0;
        chk("start_in_done_ignored", 128'(busy), 128'(1'b0));
        chk("out_count_hold",        128'(out_count), 128'(NO));

        // Run 2: abort with reset after 50 weights
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_count_clear", 128'(out_count), 128'(0));
        chk("restart_busy",        128'(busy),      128'(1'b1));
        for (int n = 0; n < 50; n++)
            send(1'b1, n / (K * K), 0, (n % (K * K)) / K, n % K);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {$urandom, $urandom};
        clear_last();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1'b0));
        chk("mid_rst_busy",     128'(busy),     128'(1'b0));
        tick();
        chk("idle_after_rst",   128'(busy),     128'(1'b0));

        // Fresh start begins again at index (0,0,0,0)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4; n++)
            send(1'b1, 0, 0, n / K, n % K);
        tick();
        chk("queue_empty_end", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
